traffic_phase_scheduler: RTL

- Actuated phase scheduler for the four-way intersection. It sequences NS/EW green, yellow and all-red phases from vehicle-sensor and pedestrian demand, instead of using fixed timers.
- Adds four features: round-robin arbitration between directions, min/max green with gap-out, per-direction walk signals, and emergency preemption.
- Drives the light and walk outputs directly.

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/traffic_demand_latch.sv | 62 ++++++
 rtl/traffic_phase_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_pkg                                                |
// | Description : Shared types and constants for the actuated four-way      |
// |               intersection phase scheduler: phase encoding, lamp codes  |
// |               and default phase timings.                                |
// | Ports       : none (package)                                            |
// | Revision    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
package traffic_pkg;

   // Phase encoding; values are visible on the phase output.
   typedef enum logic [2:0] {
      ALL_RED   = 3'b000,
      NS_GREEN  = 3'b001,
      NS_YELLOW = 3'b010,
      EW_GREEN  = 3'b011,
      EW_YELLOW = 3'b100
   } state_t;

   // One-hot lamp codes {red, yellow, green}.
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   // Default phase timings, in clock cycles.
   localparam int unsigned DEF_T_MIN_GREEN = 10;
   localparam int unsigned DEF_T_MAX_GREEN = 30;
   localparam int unsigned DEF_T_YELLOW    = 5;
   localparam int unsigned DEF_T_ALL_RED   = 2;
   localparam int unsigned DEF_T_WALK      = 6;
   localparam int unsigned DEF_CW          = 6;

endpackage
`default_nettype wire

// File: rtl/traffic_demand_latch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_demand_latch                                       |
// | Description : Per-direction demand and pedestrian latches. Holds the    |
// |               vehicle/pedestrian demand until this direction is granted |
// |               green, and snapshots the pedestrian request into a walk   |
// |               pending flag on green entry.                              |
// | Ports       : clk, rst        - clock, synchronous active-high reset    |
// |               veh_i, ped_i    - vehicle sensor / crossing button        |
// |               in_green_i      - this direction currently green          |
// |               enter_green_i   - next edge enters this direction's green |
// |               dem_o           - latched service demand                  |
// |               walk_pend_o     - walk requested for the current green    |
// | Revision    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module traffic_demand_latch (
   input  logic clk,
   input  logic rst,
   input  logic veh_i,
   input  logic ped_i,
   input  logic in_green_i,
   input  logic enter_green_i,
   output logic dem_o,
   output logic walk_pend_o
);

   logic dem_q,       dem_d;
   logic ped_q,       ped_d;
   logic walk_pend_q, walk_pend_d;

   always_comb begin
      dem_d       = dem_q;
      ped_d       = ped_q | ped_i;
      walk_pend_d = walk_pend_q;
      if (enter_green_i) begin
         // Clearing wins over setting on the grant edge. A button press on
         // that very cycle is folded into the snapshot so it is not lost.
         dem_d       = 1'b0;
         walk_pend_d = ped_q | ped_i;
         ped_d       = 1'b0;
      end else if (!in_green_i && (veh_i || ped_i)) begin
         dem_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dem_q       <= 1'b0;
         ped_q       <= 1'b0;
         walk_pend_q <= 1'b0;
      end else begin
         dem_q       <= dem_d;
         ped_q       <= ped_d;
         walk_pend_q <= walk_pend_d;
      end
   end

   assign dem_o       = dem_q;
   assign walk_pend_o = walk_pend_q;

endmodule
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_phase_scheduler                                    |
// | Description : Actuated phase scheduler for a four-way intersection.     |
// |               Sequences NS/EW green, yellow and all-red phases from     |
// |               latched vehicle/pedestrian demand with round-robin        |
// |               arbitration, min/max green with gap-out, walk signals     |
// |               and emergency preemption. All outputs are Moore outputs.  |
// | Ports       : clk, rst              - clock, sync active-high reset     |
// |               veh_ns, veh_ew        - vehicle presence levels           |
// |               ped_ns, ped_ew        - crossing buttons                  |
// |               preempt, preempt_dir  - emergency request, 0=NS 1=EW      |
// |               light_ns, light_ew    - lamps {red,yellow,green}          |
// |               walk_ns, walk_ew      - pedestrian walk                   |
// |               phase, timer          - current phase / cycles in phase   |
// |               preempt_active        - registered preempt                |
// | Revision    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned T_MIN_GREEN = DEF_T_MIN_GREEN,
   parameter int unsigned T_MAX_GREEN = DEF_T_MAX_GREEN,
   parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
   parameter int unsigned T_ALL_RED   = DEF_T_ALL_RED,
   parameter int unsigned T_WALK      = DEF_T_WALK,     // must be <= T_MIN_GREEN
   parameter int unsigned CW          = DEF_CW          // T_MAX_GREEN < 2**CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          veh_ns,
   input  logic          veh_ew,
   input  logic          ped_ns,
   input  logic          ped_ew,
   input  logic          preempt,
   input  logic          preempt_dir,
   output logic [2:0]    light_ns,
   output logic [2:0]    light_ew,
   output logic          walk_ns,
   output logic          walk_ew,
   output logic [2:0]    phase,
   output logic [CW-1:0] timer,
   output logic          preempt_active
);

   // "N cycles elapsed" is decided when the 0-based timer reaches N-1.
   localparam logic [CW-1:0] c_MIN_GREEN_M1 = CW'(T_MIN_GREEN - 1);
   localparam logic [CW-1:0] c_MAX_GREEN_M1 = CW'(T_MAX_GREEN - 1);
   localparam logic [CW-1:0] c_YELLOW_M1    = CW'(T_YELLOW - 1);
   localparam logic [CW-1:0] c_ALL_RED_M1   = CW'(T_ALL_RED - 1);
   localparam logic [CW-1:0] c_WALK         = CW'(T_WALK);
   localparam logic [CW-1:0] c_TIMER_MAX    = {CW{1'b1}};

   state_t        phase_q, phase_d;
   logic [CW-1:0] timer_q, timer_d;
   logic          rr_q,    rr_d;      // round-robin pointer: 0=NS, 1=EW
   logic          preempt_q;

   logic          w_dem_ns, w_dem_ew;
   logic          w_walk_pend_ns, w_walk_pend_ew;
   logic [1:0]    w_dem;
   logic          w_enter_ns, w_enter_ew;

   assign w_dem      = {w_dem_ew, w_dem_ns};
   assign w_enter_ns = (phase_d == NS_GREEN) && (phase_q != NS_GREEN);
   assign w_enter_ew = (phase_d == EW_GREEN) && (phase_q != EW_GREEN);

   traffic_demand_latch u_latch_ns (
      .clk           (clk),
      .rst           (rst),
      .veh_i         (veh_ns),
      .ped_i         (ped_ns),
      .in_green_i    (phase_q == NS_GREEN),
      .enter_green_i (w_enter_ns),
      .dem_o         (w_dem_ns),
      .walk_pend_o   (w_walk_pend_ns)
   );

   traffic_demand_latch u_latch_ew (
      .clk           (clk),
      .rst           (rst),
      .veh_i         (veh_ew),
      .ped_i         (ped_ew),
      .in_green_i    (phase_q == EW_GREEN),
      .enter_green_i (w_enter_ew),
      .dem_o         (w_dem_ew),
      .walk_pend_o   (w_walk_pend_ew)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q   <= ALL_RED;
         timer_q   <= '0;
         rr_q      <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         timer_q   <= timer_d;
         rr_q      <= rr_d;
         preempt_q <= preempt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      phase_d = phase_q;
      rr_d    = rr_q;

      case (phase_q)
         ALL_RED: begin
            if (timer_q >= c_ALL_RED_M1) begin
               if (preempt) begin
                  phase_d = preempt_dir ? EW_GREEN : NS_GREEN;
                  rr_d    = ~preempt_dir;
               end else if (w_dem[rr_q]) begin
                  phase_d = rr_q ? EW_GREEN : NS_GREEN;
                  rr_d    = ~rr_q;
               end else if (w_dem[~rr_q]) begin
                  phase_d = rr_q ? NS_GREEN : EW_GREEN;
                  rr_d    = rr_q;
               end
            end
         end

         NS_GREEN: begin
            if (preempt) begin
               // Preempt toward EW cuts the green short; toward NS holds it.
               if (preempt_dir) phase_d = NS_YELLOW;
            end else if (w_dem_ew && (timer_q >= c_MIN_GREEN_M1) && !veh_ns) begin
               phase_d = NS_YELLOW;
            end else if (w_dem_ew && (timer_q >= c_MAX_GREEN_M1)) begin
               phase_d = NS_YELLOW;
            end
         end

         EW_GREEN: begin
            if (preempt) begin
               if (!preempt_dir) phase_d = EW_YELLOW;
            end else if (w_dem_ns && (timer_q >= c_MIN_GREEN_M1) && !veh_ew) begin
               phase_d = EW_YELLOW;
            end else if (w_dem_ns && (timer_q >= c_MAX_GREEN_M1)) begin
               phase_d = EW_YELLOW;
            end
         end

         NS_YELLOW, EW_YELLOW: begin
            if (timer_q >= c_YELLOW_M1) phase_d = ALL_RED;
         end

         default: phase_d = ALL_RED;
      endcase

      if (phase_d != phase_q) begin
         timer_d = '0;
      end else if (timer_q != c_TIMER_MAX) begin
         timer_d = timer_q + 1'b1;
      end else begin
         timer_d = timer_q;
      end
   end

   // ------------------------------------------------------------------
   // Output decode (registered phase only)
   // ------------------------------------------------------------------
   always_comb begin
      light_ns = RED;
      light_ew = RED;
      walk_ns  = 1'b0;
      walk_ew  = 1'b0;
      case (phase_q)
         NS_GREEN: begin
            light_ns = GREEN;
            walk_ns  = w_walk_pend_ns && (timer_q < c_WALK);
         end
         NS_YELLOW: light_ns = YELLOW;
         EW_GREEN: begin
            light_ew = GREEN;
            walk_ew  = w_walk_pend_ew && (timer_q < c_WALK);
         end
         EW_YELLOW: light_ew = YELLOW;
         default: ;
      endcase
   end

   assign phase          = phase_q;
   assign timer          = timer_q;
   assign preempt_active = preempt_q;

endmodule
`default_nettype wire
